// File: rtl/decoder_scan_sequencer_pkg.sv
// decoder_scan_pkg: shared constants and the FSM state type for the
// decoder scan sequencer.
//   NUM_CH  - number of decoder output channels (3-to-8 decoder)
//   CH_W    - width of the decoder select
//   state_e - sequencer FSM state (IDLE / ACTIVE)
package decoder_scan_pkg;

   localparam int NUM_CH = 8;
   localparam int CH_W   = 3;

   typedef enum logic {
      IDLE   = 1'b0,
      ACTIVE = 1'b1
   } state_e;

endpackage

// File: rtl/decoder_scan_sequencer_if.sv
// decoder_scan_sequencer_if: control and decoder-drive bundle of the
// decoder scan sequencer.
//   start, stop, cont, dwell, mask : request side (master -> slave)
//   en, a, busy, done              : decoder drive and status (slave -> master)
//
// Request semantics: this is a level/pulse request bus, not valid/ready.
// start is a request that is accepted only on a rising clock edge where the
// sequencer is idle and stop is low; cont, dwell and mask are sampled on that
// same edge and ignored at every other time. stop is honoured on any edge and
// wins over start. busy high means a start would be ignored; done is a
// one-cycle completion pulse during which a new start is already accepted.
interface decoder_scan_sequencer_if
   import decoder_scan_pkg::*;
#(
   parameter int DWELL_W = 8
);

   logic               start;
   logic               stop;
   logic               cont;
   logic [DWELL_W-1:0] dwell;
   logic [NUM_CH-1:0]  mask;
   logic               en;
   logic [CH_W-1:0]    a;
   logic               busy;
   logic               done;

   modport master (
      output start, stop, cont, dwell, mask,
      input  en, a, busy, done
   );

   modport slave (
      input  start, stop, cont, dwell, mask,
      output en, a, busy, done
   );

endinterface

// File: rtl/decoder_scan_sequencer_scan_next_sel.sv
// scan_next_sel: combinational channel search over an enable mask.
//   mask_i       - channel enable mask, bit i = channel i
//   cur_i        - currently selected channel
//   next_found_o - a set bit exists strictly above cur_i
//   next_idx_o   - lowest set bit strictly above cur_i (0 when none)
//   first_idx_o  - lowest set bit of mask_i (0 when mask is empty)
//   any_o        - mask_i is non-zero
module scan_next_sel
   import decoder_scan_pkg::*;
(
   input  logic [NUM_CH-1:0] mask_i,
   input  logic [CH_W-1:0]   cur_i,
   output logic              next_found_o,
   output logic [CH_W-1:0]   next_idx_o,
   output logic [CH_W-1:0]   first_idx_o,
   output logic              any_o
);

   // Walk from the top channel down so the last hit written is the lowest.
   always_comb begin
      next_found_o = 1'b0;
      next_idx_o   = '0;
      first_idx_o  = '0;
      for (int i = NUM_CH - 1; i >= 0; i--) begin
         if (mask_i[i]) begin
            first_idx_o = CH_W'(i);
            if (i > int'(cur_i)) begin
               next_found_o = 1'b1;
               next_idx_o   = CH_W'(i);
            end
         end
      end
   end

   assign any_o = |mask_i;

endmodule

// File: rtl/decoder_scan_sequencer.sv
// decoder_scan_sequencer: registered scan sequencer for a 3-to-8 decoder.
// On an accepted start it steps the decoder select through every unmasked
// channel in ascending order, holding each for dwell+1 cycles, once or
// continuously, and reports busy/done.
//   clk     - system clock, rising edge
//   rst     - asynchronous, active-high reset
//   ctrl    - slave side of decoder_scan_sequencer_if (request + decoder drive)
//   state_o - current FSM state, for observation
module decoder_scan_sequencer
   import decoder_scan_pkg::*;
#(
   parameter int DWELL_W = 8
)(
   input  logic                          clk,
   input  logic                          rst,
   decoder_scan_sequencer_if.slave       ctrl,
   output state_e                        state_o
);

   state_e              state_q, state_d;
   logic [NUM_CH-1:0]   mask_q, mask_d;
   logic [DWELL_W-1:0]  dwell_q, dwell_d;
   logic                cont_q, cont_d;
   logic [DWELL_W-1:0]  cnt_q, cnt_d;
   logic                en_q, en_d;
   logic [CH_W-1:0]     a_q, a_d;
   logic                done_q, done_d;

   logic [NUM_CH-1:0]   sel_mask;
   logic                next_found;
   logic [CH_W-1:0]     next_idx;
   logic [CH_W-1:0]     first_idx;
   logic                any_set;

   // In IDLE the search must see the incoming mask (first channel of a new
   // pass); in ACTIVE it walks the latched mask from the current channel.
   assign sel_mask = (state_q == IDLE) ? ctrl.mask : mask_q;

   scan_next_sel u_next_sel (
      .mask_i       (sel_mask),
      .cur_i        (a_q),
      .next_found_o (next_found),
      .next_idx_o   (next_idx),
      .first_idx_o  (first_idx),
      .any_o        (any_set)
   );

   always_comb begin
      state_d = state_q;
      mask_d  = mask_q;
      dwell_d = dwell_q;
      cont_d  = cont_q;
      cnt_d   = cnt_q;
      en_d    = en_q;
      a_d     = a_q;
      done_d  = 1'b0;

      unique case (state_q)
         IDLE: begin
            en_d = 1'b0;
            a_d  = '0;
            if (ctrl.start && !ctrl.stop) begin
               mask_d  = ctrl.mask;
               dwell_d = ctrl.dwell;
               cont_d  = ctrl.cont;
               if (!any_set) begin
                  done_d = 1'b1;
               end else begin
                  a_d     = first_idx;
                  en_d    = 1'b1;
                  cnt_d   = ctrl.dwell;
                  state_d = ACTIVE;
               end
            end
         end
         ACTIVE: begin
            if (ctrl.stop) begin
               en_d    = 1'b0;
               a_d     = '0;
               cnt_d   = '0;
               state_d = IDLE;
            end else if (cnt_q != '0) begin
               cnt_d = cnt_q - DWELL_W'(1);
            end else if (next_found) begin
               a_d   = next_idx;
               cnt_d = dwell_q;
            end else if (cont_q) begin
               a_d   = first_idx;
               cnt_d = dwell_q;
            end else begin
               en_d    = 1'b0;
               a_d     = '0;
               done_d  = 1'b1;
               state_d = IDLE;
            end
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q <= IDLE;
         mask_q  <= '0;
         dwell_q <= '0;
         cont_q  <= 1'b0;
         cnt_q   <= '0;
         en_q    <= 1'b0;
         a_q     <= '0;
         done_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         mask_q  <= mask_d;
         dwell_q <= dwell_d;
         cont_q  <= cont_d;
         cnt_q   <= cnt_d;
         en_q    <= en_d;
         a_q     <= a_d;
         done_q  <= done_d;
      end
   end

   // en is high exactly while ACTIVE, so busy is the same register.
   assign ctrl.en   = en_q;
   assign ctrl.a    = a_q;
   assign ctrl.busy = en_q;
   assign ctrl.done = done_q;
   assign state_o   = state_q;

endmodule

// File: tb/tb_decoder_scan_sequencer.sv
// tb_decoder_scan_sequencer: directed bench for decoder_scan_sequencer.
// Inputs are driven and outputs sampled on the falling clock edge.
module tb_decoder_scan_sequencer;
   import decoder_scan_pkg::*;

   logic   clk;
   logic   rst;
   state_e state_dbg;
   int     tests;
   int     fails;

   decoder_scan_sequencer_if #(.DWELL_W(8)) bus ();

   decoder_scan_sequencer #(.DWELL_W(8)) dut (
      .clk     (clk),
      .rst     (rst),
      .ctrl    (bus),
      .state_o (state_dbg)
   );

   // ---------------- clock / reset ----------------
   initial clk = 1'b0;
   always #5 clk = ~clk;

   // {en, a[2:0], busy, done, state}
   function automatic logic [6:0] obs();
      return {bus.en, bus.a, bus.busy, bus.done, logic'(state_dbg)};
   endfunction

   function automatic logic [6:0] act(input logic [2:0] ch);
      return {1'b1, ch, 1'b1, 1'b0, 1'b1};
   endfunction

   localparam logic [6:0] IDLE_V = 7'b0_000_0_0_0;
   localparam logic [6:0] DONE_V = 7'b0_000_0_1_0;

   // ---------------- driver tasks ----------------
   task automatic issue_start(input logic [7:0] m, input logic [7:0] d, input logic c);
      @(negedge clk);
      bus.mask  = m;
      bus.dwell = d;
      bus.cont  = c;
      bus.start = 1'b1;
      @(negedge clk);
      bus.start = 1'b0;
   endtask

   // ---------------- scenarios ----------------
   task automatic test_reset();
      rst = 1'b1;
      repeat (2) @(negedge clk);
      tests++;
      if (obs() !== IDLE_V) begin
         fails++;
         $display("FAIL reset_state got %b exp %b", obs(), IDLE_V);
      end
      rst = 1'b0;
      @(negedge clk);
      tests++;
      if (obs() !== IDLE_V) begin
         fails++;
         $display("FAIL reset_release got %b exp %b", obs(), IDLE_V);
      end
   endtask

   task automatic test_single_pass();
      logic [2:0] ch[4];
      ch = '{3'd0, 3'd2, 3'd5, 3'd7};
      issue_start(8'b1010_0101, 8'd2, 1'b0);
      for (int i = 0; i < 12; i++) begin
         tests++;
         if (obs() !== act(ch[i/3])) begin
            fails++;
            $display("FAIL single_pass cyc%0d got %b exp %b", i, obs(), act(ch[i/3]));
         end
         @(negedge clk);
      end
      tests++;
      if (obs() !== DONE_V) begin
         fails++;
         $display("FAIL single_pass_done got %b exp %b", obs(), DONE_V);
      end
      @(negedge clk);
      tests++;
      if (obs() !== IDLE_V) begin
         fails++;
         $display("FAIL single_pass_after got %b exp %b", obs(), IDLE_V);
      end
   endtask

   task automatic test_continuous_stop();
      logic [2:0] e;
      issue_start(8'b1000_0001, 8'd0, 1'b1);
      for (int i = 0; i < 5; i++) begin
         e = (i % 2 == 1) ? 3'd7 : 3'd0;
         tests++;
         if (obs() !== act(e)) begin
            fails++;
            $display("FAIL cont_wrap cyc%0d got %b exp %b", i, obs(), act(e));
         end
         if (i < 4) @(negedge clk);
      end
      bus.stop = 1'b1;
      @(negedge clk);
      bus.stop = 1'b0;
      for (int i = 0; i < 2; i++) begin
         tests++;
         if (obs() !== IDLE_V) begin
            fails++;
            $display("FAIL cont_stop cyc%0d got %b exp %b", i, obs(), IDLE_V);
         end
         @(negedge clk);
      end
   endtask

   task automatic test_empty_mask();
      issue_start(8'h00, 8'd3, 1'b0);
      tests++;
      if (obs() !== DONE_V) begin
         fails++;
         $display("FAIL empty_done got %b exp %b", obs(), DONE_V);
      end
      for (int i = 0; i < 2; i++) begin
         @(negedge clk);
         tests++;
         if (obs() !== IDLE_V) begin
            fails++;
            $display("FAIL empty_after cyc%0d got %b exp %b", i, obs(), IDLE_V);
         end
      end
   endtask

   task automatic test_priority();
      logic [2:0] ch[4];
      ch = '{3'd1, 3'd1, 3'd2, 3'd2};
      // start together with stop in IDLE is dropped
      @(negedge clk);
      bus.mask  = 8'hFF;
      bus.dwell = 8'd0;
      bus.start = 1'b1;
      bus.stop  = 1'b1;
      @(negedge clk);
      bus.start = 1'b0;
      bus.stop  = 1'b0;
      for (int i = 0; i < 2; i++) begin
         tests++;
         if (obs() !== IDLE_V) begin
            fails++;
            $display("FAIL prio_start_stop cyc%0d got %b exp %b", i, obs(), IDLE_V);
         end
         @(negedge clk);
      end
      // start with new mask/dwell mid-scan is ignored
      issue_start(8'b0000_0110, 8'd1, 1'b0);
      for (int i = 0; i < 4; i++) begin
         tests++;
         if (obs() !== act(ch[i])) begin
            fails++;
            $display("FAIL prio_midscan cyc%0d got %b exp %b", i, obs(), act(ch[i]));
         end
         if (i == 0) begin
            bus.start = 1'b1;
            bus.mask  = 8'hFF;
            bus.dwell = 8'd0;
            bus.cont  = 1'b1;
         end else begin
            bus.start = 1'b0;
         end
         @(negedge clk);
      end
      tests++;
      if (obs() !== DONE_V) begin
         fails++;
         $display("FAIL prio_done got %b exp %b", obs(), DONE_V);
      end
      bus.cont = 1'b0;
      @(negedge clk);
   endtask

   task automatic test_back_to_back();
      issue_start(8'b0000_1000, 8'd0, 1'b0);
      tests++;
      if (obs() !== act(3'd3)) begin
         fails++;
         $display("FAIL b2b_first got %b exp %b", obs(), act(3'd3));
      end
      @(negedge clk);
      tests++;
      if (obs() !== DONE_V) begin
         fails++;
         $display("FAIL b2b_done got %b exp %b", obs(), DONE_V);
      end
      bus.mask  = 8'b0001_0000;
      bus.dwell = 8'd1;
      bus.start = 1'b1;
      @(negedge clk);
      bus.start = 1'b0;
      for (int i = 0; i < 2; i++) begin
         tests++;
         if (obs() !== act(3'd4)) begin
            fails++;
            $display("FAIL b2b_second cyc%0d got %b exp %b", i, obs(), act(3'd4));
         end
         @(negedge clk);
      end
      tests++;
      if (obs() !== DONE_V) begin
         fails++;
         $display("FAIL b2b_second_done got %b exp %b", obs(), DONE_V);
      end
      @(negedge clk);
   endtask

   task automatic test_reset_mid_scan();
      issue_start(8'b0010_0000, 8'd1, 1'b1);
      for (int i = 0; i < 6; i++) begin
         tests++;
         if (obs() !== act(3'd5)) begin
            fails++;
            $display("FAIL single_bit_cont cyc%0d got %b exp %b", i, obs(), act(3'd5));
         end
         if (i < 5) @(negedge clk);
      end
      rst = 1'b1;
      #1;
      tests++;
      if (obs() !== IDLE_V) begin
         fails++;
         $display("FAIL rst_async got %b exp %b", obs(), IDLE_V);
      end
      @(negedge clk);
      rst = 1'b0;
      for (int i = 0; i < 3; i++) begin
         @(negedge clk);
         tests++;
         if (obs() !== IDLE_V) begin
            fails++;
            $display("FAIL rst_no_done cyc%0d got %b exp %b", i, obs(), IDLE_V);
         end
      end
   endtask

   task automatic test_max_dwell();
      issue_start(8'b0000_0011, 8'hFF, 1'b0);
      for (int i = 0; i < 512; i++) begin
         tests++;
         if (obs() !== act(3'(i / 256))) begin
            fails++;
            $display("FAIL max_dwell cyc%0d got %b exp %b", i, obs(), act(3'(i / 256)));
         end
         @(negedge clk);
      end
      tests++;
      if (obs() !== DONE_V) begin
         fails++;
         $display("FAIL max_dwell_done got %b exp %b", obs(), DONE_V);
      end
      @(negedge clk);
   endtask

   // ---------------- sequence + report ----------------
   initial begin
      tests     = 0;
      fails     = 0;
      rst       = 1'b1;
      bus.start = 1'b0;
      bus.stop  = 1'b0;
      bus.cont  = 1'b0;
      bus.dwell = '0;
      bus.mask  = '0;

      test_reset();
      test_single_pass();
      test_continuous_stop();
      test_empty_mask();
      test_priority();
      test_back_to_back();
      test_reset_mid_scan();
      test_max_dwell();

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
